// File: rtl/amp_meter.sv
// Amplitude meter: programmable threshold table -> registered thermometer bar.
// Optional peak-hold/decay bar enabled by defining AMP_PEAK_HOLD_EN.
module amp_meter #(
  parameter int DATA_W    = 8,
  parameter int LEVELS    = 16,
  parameter int HOLD_CYC  = 1024,
  parameter int DECAY_CYC = 64,
  localparam int AW = $clog2(LEVELS),
  localparam int PW = $clog2(LEVELS + 1)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              thr_we,
  input  logic [AW-1:0]     thr_addr,
  input  logic [DATA_W-1:0] thr_wdata,
  input  logic              peak_clr,
  output logic              out_valid,
  output logic [LEVELS-1:0] ap,
  output logic [PW-1:0]     peak_lvl,
  output logic [LEVELS-1:0] peak_ap
);

  // Square-law default: ((k+1)^2 * 2^DATA_W) / LEVELS^2, clipped to full scale.
  function automatic logic [DATA_W-1:0] thr_default(input int k);
    longint unsigned kk, ll, num, full;
    kk   = 64'(k) + 64'd1;
    ll   = 64'(LEVELS);
    full = (64'd1 << DATA_W) - 64'd1;
    num  = ((kk * kk) << DATA_W) / (ll * ll);
    if (num > full) num = full;
    return num[DATA_W-1:0];
  endfunction

  logic [LEVELS-1:0] cmp;
  logic [LEVELS-1:0] ap_q, ap_d;
  logic              vld_q;

  // Out-of-range addresses match no entry, so such writes fall away naturally.
  for (genvar k = 0; k < LEVELS; k++) begin : g_thr
    logic [DATA_W-1:0] thr_q;
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
        thr_q <= thr_default(k);
      else if (thr_we && (thr_addr == AW'(k)))
        thr_q <= thr_wdata;
    end
    assign cmp[k] = (data > thr_q);
  end

  assign ap_d = data_valid ? cmp : ap_q;

  // Stage boundary: compare vector -> registered bar
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ap_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      ap_q  <= ap_d;
      vld_q <= data_valid;
    end
  end

  assign ap        = ap_q;
  assign out_valid = vld_q;

`ifdef AMP_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int DW = $clog2(DECAY_CYC + 1);

  typedef enum logic [1:0] {P_IDLE, P_HOLD, P_DECAY} pstate_t;

  function automatic logic [PW-1:0] popcount(input logic [LEVELS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < LEVELS; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  function automatic logic [LEVELS-1:0] therm(input logic [PW-1:0] l);
    logic [LEVELS-1:0] t;
    for (int i = 0; i < LEVELS; i++) t[i] = (i < int'(l));
    return t;
  endfunction

  pstate_t           st_q, st_d;
  logic [PW-1:0]     lvl, peak_q, peak_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DW-1:0]     dec_q, dec_d;
  logic [LEVELS-1:0] peak_ap_q;

  assign lvl = popcount(cmp);

  always_comb begin
    st_d   = st_q;
    peak_d = peak_q;
    hold_d = hold_q;
    dec_d  = dec_q;
    if (peak_clr) begin
      st_d   = P_IDLE;
      peak_d = '0;
      hold_d = '0;
      dec_d  = '0;
    end else if (data_valid && (lvl >= peak_q)) begin
      st_d   = P_HOLD;
      peak_d = lvl;
      hold_d = HW'(HOLD_CYC);
      dec_d  = '0;
    end else begin
      case (st_q)
        P_HOLD: begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) st_d = (peak_q == '0) ? P_IDLE : P_DECAY;
        end
        P_DECAY: begin
          if (dec_q == DW'(DECAY_CYC - 1)) begin
            dec_d  = '0;
            peak_d = peak_q - 1'b1;
            if (peak_q == PW'(1)) st_d = P_IDLE;
          end else begin
            dec_d = dec_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: peak state and its thermometer registered together
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= P_IDLE;
      peak_q    <= '0;
      hold_q    <= '0;
      dec_q     <= '0;
      peak_ap_q <= '0;
    end else begin
      st_q      <= st_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      dec_q     <= dec_d;
      peak_ap_q <= therm(peak_d);
    end
  end

  assign peak_lvl = peak_q;
  assign peak_ap  = peak_ap_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_lvl        = '0;
  assign peak_ap         = '0;
`endif

endmodule

// File: tb/tb_amp_meter.sv
// Directed bench for amp_meter (DATA_W=8, LEVELS=16, HOLD_CYC=4, DECAY_CYC=2)
// with an expected-bar queue and a closed-form peak model.
module tb_amp_meter;
  localparam int HOLD  = 4;
  localparam int DECAY = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  data = '0;
  logic        thr_we = 1'b0;
  logic [3:0]  thr_addr = '0;
  logic [7:0]  thr_wdata = '0;
  logic        peak_clr = 1'b0;
  logic        out_valid;
  logic [15:0] ap;
  logic [4:0]  peak_lvl;
  logic [15:0] peak_ap;

  amp_meter #(.DATA_W(8), .LEVELS(16), .HOLD_CYC(HOLD), .DECAY_CYC(DECAY)) dut (
    .clock(clock), .rst_n(rst_n), .data_valid(data_valid), .data(data),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_wdata(thr_wdata),
    .peak_clr(peak_clr), .out_valid(out_valid), .ap(ap),
    .peak_lvl(peak_lvl), .peak_ap(peak_ap)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          npass = 0;
  int          ntotal = 0;
  logic [7:0]  m_thr [16];
  logic [15:0] exp_q [$];
  logic [15:0] m_last_ap;
  int          m_L, m_j;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_thr[k] = ((k + 1) * (k + 1) > 255) ? 8'd255 : 8'((k + 1) * (k + 1));
    exp_q.delete();
    m_last_ap = '0;
    m_L = 0;
    m_j = 0;
  endtask

  // Peak after j edges since the last refresh to level L.
  function automatic int cur_peak();
    int p;
`ifdef AMP_PEAK_HOLD_EN
    if (m_j < HOLD) p = m_L;
    else p = m_L - (m_j - HOLD) / DECAY;
    if (p < 0) p = 0;
`else
    p = 0;
`endif
    return p;
  endfunction

  function automatic logic [15:0] therm(input int p);
    logic [31:0] t;
    t = (32'd1 << p) - 32'd1;
    return t[15:0];
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic we,
                      input logic [3:0] a, input logic [7:0] wd, input logic clr);
    logic [15:0] e;
    int          lvl, pre;
    data_valid = v; data = d; thr_we = we; thr_addr = a; thr_wdata = wd; peak_clr = clr;
    for (int k = 0; k < 16; k++) e[k] = (d > m_thr[k]);
    lvl = $countones(e);
    if (v) exp_q.push_back(e);
    pre = cur_peak();
    @(posedge clock);
    if (we) m_thr[a] = wd;
    if (clr) begin m_L = 0; m_j = 0; end
    else if (v && lvl >= pre) begin m_L = lvl; m_j = 0; end
    else m_j++;
    #1;
    data_valid = 1'b0; thr_we = 1'b0; peak_clr = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("ap_unexpected", 32'(out_valid), 32'd0);
      else begin
        m_last_ap = exp_q.pop_front();
        chk("ap", 32'(ap), 32'(m_last_ap));
      end
    end else begin
      chk("ap_hold", 32'(ap), 32'(m_last_ap));
    end
    chk("peak_lvl", 32'(peak_lvl), 32'(cur_peak()));
    chk("peak_ap", 32'(peak_ap), 32'(therm(cur_peak())));
  endtask

  task automatic sample(input logic [7:0] d);
    step(1'b1, d, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ap", 32'(ap), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_peak_lvl", 32'(peak_lvl), 32'd0);
    chk("rst_peak_ap", 32'(peak_ap), 32'd0);
    rst_n = 1'b1;

    // Default table
    sample(8'd50);
    chk("ap_50_const", 32'(ap), 32'h007F);
    sample(8'd255);
    chk("ap_255_const", 32'(ap), 32'h7FFF);
    sample(8'd0);
    chk("ap_0_const", 32'(ap), 32'h0000);
    idle(3);

    // Write during a sample uses the old threshold
    step(1'b1, 8'd100, 1'b1, 4'd0, 8'd200, 1'b0);
    chk("ap_old_thr_bit0", 32'(ap[0]), 32'd1);
    sample(8'd100);
    chk("ap_new_thr_bit0", 32'(ap[0]), 32'd0);
    step(1'b0, 8'd0, 1'b1, 4'd0, 8'd1, 1'b0);
    idle(2);

    // Hold then decay to zero
    sample(8'd100);
    idle(HOLD + 9 * DECAY + 4);

    // Refresh rules and clear priority
    sample(8'd100);
    idle(1);
    sample(8'd30);
    idle(1);
    sample(8'd255);
    idle(3);
    step(1'b1, 8'd255, 1'b0, 4'd0, 8'd0, 1'b1);
    chk("clr_ap", 32'(ap), 32'h7FFF);
    chk("clr_peak", 32'(peak_lvl), 32'd0);
    idle(2);

    // Dirty the table, enter decay, then reset asynchronously
    step(1'b0, 8'd0, 1'b1, 4'd3, 8'd0, 1'b0);
    sample(8'd200);
    idle(HOLD + DECAY + 1);
    rst_n = 1'b0;
    #2;
    chk("arst_ap", 32'(ap), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_peak_lvl", 32'(peak_lvl), 32'd0);
    chk("arst_peak_ap", 32'(peak_ap), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    sample(8'd10);
    chk("ap_default_after_rst", 32'(ap), 32'h0007);
    idle(2);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
